// File: rtl/seq_signed_multiplier_if.sv
// -----------------------------------------------------------------------------
// seq_signed_multiplier_if
// Handshake and operand/result bundle for seq_signed_multiplier.
//   start        : level request, sampled by the multiplier while idle
//   signed_mode  : 1 = operands are two's complement, 0 = unsigned
//   multiplier   : operand B (W bits)
//   multiplicand : operand A (W bits)
//   product      : 2W-bit result (two's complement in signed mode)
//   magnitude    : 2W-bit absolute value of the result
//   negative     : result is strictly negative
//   done         : result valid (multiplier in FINISH)
//   busy         : multiplication in progress (multiplier in RUN)
// master = requester side, slave = multiplier side.
// -----------------------------------------------------------------------------
interface seq_signed_multiplier_if #(
  parameter int W = 8
) ();
  logic             start;
  logic             signed_mode;
  logic [W-1:0]     multiplier;
  logic [W-1:0]     multiplicand;
  logic [2*W-1:0]   product;
  logic [2*W-1:0]   magnitude;
  logic             negative;
  logic             done;
  logic             busy;

  modport master (
    output start, signed_mode, multiplier, multiplicand,
    input  product, magnitude, negative, done, busy
  );

  modport slave (
    input  start, signed_mode, multiplier, multiplicand,
    output product, magnitude, negative, done, busy
  );
endinterface

// File: rtl/seq_signed_multiplier.sv
// -----------------------------------------------------------------------------
// seq_signed_multiplier
// Sequential shift-add multiplier with selectable signed/unsigned operands.
// Operands are converted to sign/magnitude at load, the magnitudes are
// multiplied one multiplier bit per clock, and the sign is re-applied when the
// result is written. Produces a two's-complement product plus a
// (negative, magnitude) pair for the BCD/display path.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset (0 = reset)
//   bus  : seq_signed_multiplier_if.slave (start/done/busy handshake,
//          operands, product/magnitude/negative results)
//
// Parameters:
//   IN_WIDTH : operand width W (W >= 2); product/magnitude are 2W bits.
//
// Optional feature (compile-time macro SEQ_MULT_EARLY_EXIT_EN):
//   When defined, RUN finishes as soon as the remaining multiplier bits are
//   all zero, so latency tracks the highest set bit of |multiplier|.
//   When undefined, latency is always W edges after the load edge.
// -----------------------------------------------------------------------------
module seq_signed_multiplier #(
  parameter int IN_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  seq_signed_multiplier_if.slave  bus
);

  localparam int W  = IN_WIDTH;
  localparam int PW = 2 * W;
  localparam int CW = $clog2(W + 1);

  // Explicit encoding; 2'b11 is illegal and falls back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FINISH = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sign_q, sign_d;
  logic [PW-1:0]   product_q, product_d;
  logic [PW-1:0]   magnitude_q, magnitude_d;
  logic            negative_q, negative_d;

  logic [W-1:0]    abs_mcand;
  logic [W-1:0]    abs_mplier;
  logic [PW-1:0]   acc_final;
  logic            last_iter;
  logic            finish_now;
  logic            res_neg;

  // |x| for the load edge. -2^(W-1) negates to itself, which read as unsigned
  // is exactly 2^(W-1), so no extra bit is needed.
  function automatic logic [W-1:0] abs_op(input logic [W-1:0] x, input logic sm);
    return (sm && x[W-1]) ? -x : x;
  endfunction

  assign abs_mcand  = abs_op(bus.multiplicand, bus.signed_mode);
  assign abs_mplier = abs_op(bus.multiplier, bus.signed_mode);

  // Accumulator value including this edge's conditional add. Both operands are
  // magnitudes < 2^W, so the 2W-bit sum never overflows.
  assign acc_final  = acc_q + (b_q[0] ? a_q : '0);
  assign last_iter  = (cnt_q == CW'(W - 1));
  assign res_neg    = sign_q & (|acc_final);

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a hold/default value first so no path through
    // the case statement leaves one unassigned, which would infer a latch.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    product_d   = product_q;
    magnitude_d = magnitude_q;
    negative_d  = negative_q;
    finish_now  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = PW'(abs_mcand);
          b_d     = abs_mplier;
          sign_d  = bus.signed_mode &
                    (bus.multiplicand[W-1] ^ bus.multiplier[W-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        finish_now = last_iter;
`ifdef SEQ_MULT_EARLY_EXIT_EN
        // With B == 0, b_q[0] is 0 so acc_final already equals acc_q:
        // the early write uses the current accumulator with no add.
        if (b_q == '0) begin
          finish_now = 1'b1;
        end
`endif
        acc_d = acc_final;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (finish_now) begin
          state_d     = ST_FINISH;
          magnitude_d = acc_final;
          negative_d  = res_neg;
          product_d   = res_neg ? -acc_final : acc_final;
        end
      end

      ST_FINISH: begin
        // Held start keeps the result on display; no automatic restart.
        if (!bus.start) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      product_q   <= '0;
      magnitude_q <= '0;
      negative_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      product_q   <= product_d;
      magnitude_q <= magnitude_d;
      negative_q  <= negative_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: results are registers; done/busy decode the registered state only.
  // ---------------------------------------------------------------------------
  assign bus.product   = product_q;
  assign bus.magnitude = magnitude_q;
  assign bus.negative  = negative_q;
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_FINISH);

endmodule
